// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package mem_arb_pkg;

   // Arbiter transaction FSM
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Master ids; also the bit positions in the request/grant vectors
   localparam logic MID_I = 1'b0;
   localparam logic MID_D = 1'b1;

   // Width of a counter that must hold the value RD_LAT-1 (and RD_LAT)
   function automatic int lat_cnt_w(input int rd_lat);
      return $clog2(rd_lat + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response channels of both core masters plus the RAM port.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Instruction fetch master
   logic                i_req_valid;
   logic                i_req_ready;
   logic [ADDR_W-1:0]   i_req_addr;
   logic                i_rsp_valid;
   logic [DATA_W-1:0]   i_rsp_rdata;

   // Data access master
   logic                d_req_valid;
   logic                d_req_ready;
   logic [ADDR_W-1:0]   d_req_addr;
   logic                d_req_wen;
   logic [DATA_W-1:0]   d_req_wdata;
   logic [DATA_W/8-1:0] d_req_wstrb;
   logic                d_rsp_valid;
   logic [DATA_W-1:0]   d_rsp_rdata;

   // Single-port synchronous RAM
   logic                mem_en;
   logic                mem_wen;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic [DATA_W-1:0]   mem_rdata;

   // Arbiter side
   modport slave (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_rsp_valid, i_rsp_rdata,
      input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wstrb,
      output d_req_ready, d_rsp_valid, d_rsp_rdata,
      output mem_en, mem_wen, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata
   );

   // Core masters and RAM side
   modport master (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_rsp_valid, i_rsp_rdata,
      output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wstrb,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata,
      input  mem_en, mem_wen, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way grant logic: fixed D priority or round-robin on contention.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_prio_d,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

   logic r_last;

   // One-hot grant; on a tie favour D when prioritised, else the master not served last
   always_comb begin
      // NOTE: default first so every path assigns o_gnt and no latch is inferred.
      o_gnt = 2'b00;
      unique case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (i_prio_d || (r_last == MID_I)) ? 2'b10 : 2'b01;
         default: o_gnt = 2'b00;
      endcase
   end

   // Remember who was served last; starting at D lets I win the first tie
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state so register updates are order-independent.
      if (rst) begin
         r_last <= MID_D;
      end else if (i_accept) begin
         r_last <= o_gnt[MID_D];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-fetch and D-access requests onto one single-port synchronous RAM.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1,
   parameter int D_PRIO = 0
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = lat_cnt_w(RD_LAT);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [1:0]          w_req;
   logic [1:0]          w_gnt;
   logic                w_accept;

   // Latched request fields, held for the life of the transaction
   logic                r_mid;
   logic                r_wen;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic [CNT_W-1:0]    r_cnt;

   // Per-master response data, held between responses
   logic [DATA_W-1:0]   r_i_rdata;
   logic [DATA_W-1:0]   r_d_rdata;

   assign w_req = {bus.d_req_valid, bus.i_req_valid};

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst      (rst),
      .i_req    (w_req),
      .i_prio_d (D_PRIO != 0),
      .i_accept (w_accept),
      .o_gnt    (w_gnt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus the strobes decoded from the current state
   always_comb begin
      w_state_nxt     = r_state;
      w_accept        = 1'b0;
      bus.i_req_ready = 1'b0;
      bus.d_req_ready = 1'b0;
      bus.mem_en      = 1'b0;
      bus.mem_wen     = 1'b0;
      bus.mem_wstrb   = '0;
      bus.i_rsp_valid = 1'b0;
      bus.d_rsp_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            // A request coinciding with reset is never accepted
            if (!rst) begin
               bus.i_req_ready = w_gnt[MID_I];
               bus.d_req_ready = w_gnt[MID_D];
               if (w_gnt != 2'b00) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ACCESS;
               end
            end
         end
         ACCESS: begin
            bus.mem_en    = 1'b1;
            bus.mem_wen   = r_wen;
            bus.mem_wstrb = r_wen ? r_wstrb : '0;
            w_state_nxt   = r_wen ? RESP : WAIT;
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            bus.i_rsp_valid = (r_mid == MID_I);
            bus.d_rsp_valid = (r_mid == MID_D);
            w_state_nxt     = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request latch, read-latency counter and response capture
   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, since they drive outputs that must read 0 after reset.
      if (rst) begin
         r_mid     <= MID_I;
         r_wen     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_cnt     <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_accept) begin
            if (w_gnt[MID_D]) begin
               r_mid   <= MID_D;
               r_addr  <= bus.d_req_addr;
               r_wen   <= bus.d_req_wen;
               r_wdata <= bus.d_req_wdata;
               r_wstrb <= bus.d_req_wstrb;
            end else begin
               // Fetch is read-only; write data/strobes keep their last values
               r_mid   <= MID_I;
               r_addr  <= bus.i_req_addr;
               r_wen   <= 1'b0;
            end
         end

         if (r_state == ACCESS) begin
            if (r_wen) begin
               r_d_rdata <= '0;
            end else begin
               r_cnt <= CNT_W'(RD_LAT - 1);
            end
         end

         // The RAM data is valid only in the WAIT cycle where the counter is 0
         if (r_state == WAIT) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
            end else if (r_mid == MID_D) begin
               r_d_rdata <= bus.mem_rdata;
            end else begin
               r_i_rdata <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_addr    = r_addr;
   assign bus.mem_wdata   = r_wdata;
   assign bus.i_rsp_rdata = r_i_rdata;
   assign bus.d_rsp_rdata = r_d_rdata;
   assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter in three configurations.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy_a, busy_b, busy_c;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   // a: RD_LAT=1 round-robin, b: RD_LAT=1 D priority, c: RD_LAT=3 round-robin
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_c ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .D_PRIO(0)) u_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave), .busy(busy_a));
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .D_PRIO(1)) u_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave), .busy(busy_b));
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .D_PRIO(0)) u_c (
      .clk(clk), .rst(rst), .bus(bus_c.slave), .busy(busy_c));

   // Control bits: {i_ready, d_ready, mem_en, mem_wen, i_rsp_valid, d_rsp_valid, busy}
   wire [6:0] ctl_a = {bus_a.i_req_ready, bus_a.d_req_ready, bus_a.mem_en, bus_a.mem_wen,
                       bus_a.i_rsp_valid, bus_a.d_rsp_valid, busy_a};
   wire [6:0] ctl_b = {bus_b.i_req_ready, bus_b.d_req_ready, bus_b.mem_en, bus_b.mem_wen,
                       bus_b.i_rsp_valid, bus_b.d_rsp_valid, busy_b};
   wire [6:0] ctl_c = {bus_c.i_req_ready, bus_c.d_req_ready, bus_c.mem_en, bus_c.mem_wen,
                       bus_c.i_rsp_valid, bus_c.d_rsp_valid, busy_c};

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      bus_a.i_req_valid = 0; bus_a.i_req_addr = '0; bus_a.d_req_valid = 0; bus_a.d_req_addr = '0;
      bus_a.d_req_wen = 0; bus_a.d_req_wdata = '0; bus_a.d_req_wstrb = '0; bus_a.mem_rdata = '0;
      bus_b.i_req_valid = 0; bus_b.i_req_addr = '0; bus_b.d_req_valid = 0; bus_b.d_req_addr = '0;
      bus_b.d_req_wen = 0; bus_b.d_req_wdata = '0; bus_b.d_req_wstrb = '0; bus_b.mem_rdata = '0;
      bus_c.i_req_valid = 0; bus_c.i_req_addr = '0; bus_c.d_req_valid = 0; bus_c.d_req_addr = '0;
      bus_c.d_req_wen = 0; bus_c.d_req_wdata = '0; bus_c.d_req_wstrb = '0; bus_c.mem_rdata = '0;
   endtask

   // Reset with requests present: nothing accepted, all outputs zero
   task automatic test_reset();
      tick();
      bus_a.i_req_valid = 1; bus_a.d_req_valid = 1;
      bus_b.i_req_valid = 1; bus_b.d_req_valid = 1;
      bus_c.i_req_valid = 1;
      sample();
      n_tests++; if (ctl_a !== 7'b0) begin n_fail++; $display("FAIL rst_ctl_a: got %b want %b", ctl_a, 7'b0); end
      n_tests++; if (ctl_b !== 7'b0) begin n_fail++; $display("FAIL rst_ctl_b: got %b want %b", ctl_b, 7'b0); end
      n_tests++; if (ctl_c !== 7'b0) begin n_fail++; $display("FAIL rst_ctl_c: got %b want %b", ctl_c, 7'b0); end
      tick();
      rst = 0;
      drive_idle();
      sample();
      n_tests++; if (ctl_a !== 7'b0) begin n_fail++; $display("FAIL post_rst_ctl: got %b want %b", ctl_a, 7'b0); end
      n_tests++; if (bus_a.mem_addr !== 32'h0) begin n_fail++; $display("FAIL post_rst_addr: got %h want %h", bus_a.mem_addr, 32'h0); end
      n_tests++; if (bus_a.i_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL post_rst_irdata: got %h want %h", bus_a.i_rsp_rdata, 32'h0); end
   endtask

   // Single fetch read, RD_LAT=1
   task automatic test_i_read();
      logic [6:0] exp_ctl [5] = '{7'b1000000, 7'b0010001, 7'b0000001, 7'b0000101, 7'b0000000};
      for (int k = 0; k < 5; k++) begin
         tick();
         bus_a.i_req_valid = (k == 0);
         bus_a.i_req_addr  = 32'h8000_0000;
         bus_a.mem_rdata   = (k == 2) ? 32'h0000_0413 : 32'hFFFF_FFFF;
         sample();
         n_tests++; if (ctl_a !== exp_ctl[k]) begin n_fail++; $display("FAIL iread_ctl k=%0d: got %b want %b", k, ctl_a, exp_ctl[k]); end
         if (k == 1) begin
            n_tests++; if (bus_a.mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL iread_addr: got %h want %h", bus_a.mem_addr, 32'h8000_0000); end
         end
         if (k >= 3) begin
            n_tests++; if (bus_a.i_rsp_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL iread_data k=%0d: got %h want %h", k, bus_a.i_rsp_rdata, 32'h0000_0413); end
         end
      end
   endtask

   // Single data write with partial strobes
   task automatic test_d_write();
      logic [6:0] exp_ctl [4] = '{7'b0100000, 7'b0011001, 7'b0000011, 7'b0000000};
      for (int k = 0; k < 4; k++) begin
         tick();
         bus_a.d_req_valid = (k == 0);
         bus_a.d_req_wen   = 1;
         bus_a.d_req_addr  = 32'h0000_0010;
         bus_a.d_req_wdata = 32'hDEAD_BEEF;
         bus_a.d_req_wstrb = 4'h3;
         sample();
         n_tests++; if (ctl_a !== exp_ctl[k]) begin n_fail++; $display("FAIL dwr_ctl k=%0d: got %b want %b", k, ctl_a, exp_ctl[k]); end
         if (k == 1) begin
            n_tests++; if (bus_a.mem_wstrb !== 4'h3) begin n_fail++; $display("FAIL dwr_strb: got %h want %h", bus_a.mem_wstrb, 4'h3); end
            n_tests++; if (bus_a.mem_addr !== 32'h10) begin n_fail++; $display("FAIL dwr_addr: got %h want %h", bus_a.mem_addr, 32'h10); end
            n_tests++; if (bus_a.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dwr_wdata: got %h want %h", bus_a.mem_wdata, 32'hDEAD_BEEF); end
         end
         if (k == 2) begin
            n_tests++; if (bus_a.d_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL dwr_rdata: got %h want %h", bus_a.d_rsp_rdata, 32'h0); end
         end
      end
      bus_a.d_req_wen = 0;
   endtask

   // Both masters request continuously; grants alternate starting with I
   task automatic test_round_robin();
      logic [6:0]  exp;
      logic [31:0] exp_d;
      bit          gi;
      for (int k = 0; k < 17; k++) begin
         tick();
         bus_a.i_req_valid = (k < 16);
         bus_a.i_req_addr  = 32'h0000_0100;
         bus_a.d_req_valid = (k < 16);
         bus_a.d_req_addr  = 32'h0000_0200;
         bus_a.d_req_wen   = 0;
         bus_a.mem_rdata   = 32'hA000_0000 + 32'(k);
         sample();
         gi = ((k / 4) % 2 == 0);
         case (k % 4)
            0:       exp = (k == 16) ? 7'b0 : {gi, !gi, 5'b00000};
            1:       exp = 7'b0010001;
            2:       exp = 7'b0000001;
            default: exp = gi ? 7'b0000101 : 7'b0000011;
         endcase
         n_tests++; if (ctl_a !== exp) begin n_fail++; $display("FAIL rr_ctl k=%0d: got %b want %b", k, ctl_a, exp); end
         if (k % 4 == 1) begin
            exp_d = gi ? 32'h100 : 32'h200;
            n_tests++; if (bus_a.mem_addr !== exp_d) begin n_fail++; $display("FAIL rr_addr k=%0d: got %h want %h", k, bus_a.mem_addr, exp_d); end
         end
         if (k % 4 == 3) begin
            exp_d = 32'hA000_0000 + 32'(k - 1);
            if (gi) begin
               n_tests++; if (bus_a.i_rsp_rdata !== exp_d) begin n_fail++; $display("FAIL rr_idata k=%0d: got %h want %h", k, bus_a.i_rsp_rdata, exp_d); end
            end else begin
               n_tests++; if (bus_a.d_rsp_rdata !== exp_d) begin n_fail++; $display("FAIL rr_ddata k=%0d: got %h want %h", k, bus_a.d_rsp_rdata, exp_d); end
            end
         end
      end
   endtask

   // Zero-strobe write is still acknowledged; a withdrawn I request is ignored
   task automatic test_write_no_strobe();
      logic [6:0] exp_ctl [4] = '{7'b0100000, 7'b0011001, 7'b0000011, 7'b0000000};
      for (int k = 0; k < 4; k++) begin
         tick();
         bus_a.d_req_valid = (k == 0);
         bus_a.d_req_wen   = 1;
         bus_a.d_req_addr  = 32'h0000_0014;
         bus_a.d_req_wdata = 32'h1234_5678;
         bus_a.d_req_wstrb = 4'h0;
         bus_a.i_req_valid = (k == 1);
         bus_a.i_req_addr  = 32'h0000_0999;
         sample();
         n_tests++; if (ctl_a !== exp_ctl[k]) begin n_fail++; $display("FAIL wz_ctl k=%0d: got %b want %b", k, ctl_a, exp_ctl[k]); end
         if (k == 1) begin
            n_tests++; if (bus_a.mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL wz_strb: got %h want %h", bus_a.mem_wstrb, 4'h0); end
            n_tests++; if (bus_a.mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wz_wdata: got %h want %h", bus_a.mem_wdata, 32'h1234_5678); end
         end
         if (k == 2) begin
            n_tests++; if (bus_a.d_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wz_rdata: got %h want %h", bus_a.d_rsp_rdata, 32'h0); end
         end
      end
      bus_a.d_req_wen = 0;
   endtask

   // D priority: D wins every tie, I served once D drops
   task automatic test_d_prio();
      logic [6:0]  exp;
      logic [31:0] exp_d;
      for (int k = 0; k < 17; k++) begin
         tick();
         bus_b.d_req_valid = (k < 12);
         bus_b.d_req_addr  = 32'h0000_0200;
         bus_b.d_req_wen   = 0;
         bus_b.i_req_valid = (k < 13);
         bus_b.i_req_addr  = 32'h0000_0100;
         bus_b.mem_rdata   = 32'hB000_0000 + 32'(k);
         sample();
         if (k == 16) exp = 7'b0;
         else if (k == 12) exp = 7'b1000000;
         else if (k > 12) exp = (k == 13) ? 7'b0010001 : (k == 14) ? 7'b0000001 : 7'b0000101;
         else begin
            case (k % 4)
               0:       exp = 7'b0100000;
               1:       exp = 7'b0010001;
               2:       exp = 7'b0000001;
               default: exp = 7'b0000011;
            endcase
         end
         n_tests++; if (ctl_b !== exp) begin n_fail++; $display("FAIL prio_ctl k=%0d: got %b want %b", k, ctl_b, exp); end
         if (k % 4 == 1) begin
            exp_d = (k == 13) ? 32'h100 : 32'h200;
            n_tests++; if (bus_b.mem_addr !== exp_d) begin n_fail++; $display("FAIL prio_addr k=%0d: got %h want %h", k, bus_b.mem_addr, exp_d); end
         end
         if (k % 4 == 3 && k < 12) begin
            exp_d = 32'hB000_0000 + 32'(k - 1);
            n_tests++; if (bus_b.d_rsp_rdata !== exp_d) begin n_fail++; $display("FAIL prio_ddata k=%0d: got %h want %h", k, bus_b.d_rsp_rdata, exp_d); end
         end
         if (k == 15) begin
            n_tests++; if (bus_b.i_rsp_rdata !== 32'hB000_000E) begin n_fail++; $display("FAIL prio_idata: got %h want %h", bus_b.i_rsp_rdata, 32'hB000_000E); end
         end
      end
   endtask

   // RD_LAT=3: only the data present in the last WAIT cycle is captured
   task automatic test_rd_lat3();
      logic [6:0]  exp_ctl [7] = '{7'b1000000, 7'b0010001, 7'b0000001, 7'b0000001,
                                   7'b0000001, 7'b0000101, 7'b0000000};
      logic [31:0] rd_in   [7] = '{32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222,
                                   32'h3333_3333, 32'h4444_4444, 32'h0};
      for (int k = 0; k < 7; k++) begin
         tick();
         bus_c.i_req_valid = (k == 0);
         bus_c.i_req_addr  = 32'h0000_3000;
         bus_c.mem_rdata   = rd_in[k];
         sample();
         n_tests++; if (ctl_c !== exp_ctl[k]) begin n_fail++; $display("FAIL lat3_ctl k=%0d: got %b want %b", k, ctl_c, exp_ctl[k]); end
         if (k >= 5) begin
            n_tests++; if (bus_c.i_rsp_rdata !== 32'h3333_3333) begin n_fail++; $display("FAIL lat3_data k=%0d: got %h want %h", k, bus_c.i_rsp_rdata, 32'h3333_3333); end
         end
      end
   endtask

   // Reset during WAIT aborts the read; a new fetch is accepted right after
   task automatic test_rst_in_wait();
      logic [6:0] exp_ctl [7] = '{7'b1000000, 7'b0010001, 7'b0000001, 7'b1000000,
                                  7'b0010001, 7'b0000001, 7'b0000101};
      for (int k = 0; k < 7; k++) begin
         tick();
         rst               = (k == 2);
         bus_a.i_req_valid = (k == 0) || (k == 3);
         bus_a.i_req_addr  = (k < 3) ? 32'h0000_0080 : 32'h0000_0040;
         bus_a.mem_rdata   = (k == 2) ? 32'h9999_9999 : (k == 5) ? 32'h55AA_55AA : 32'h0;
         sample();
         n_tests++; if (ctl_a !== exp_ctl[k]) begin n_fail++; $display("FAIL rstw_ctl k=%0d: got %b want %b", k, ctl_a, exp_ctl[k]); end
         if (k == 3) begin
            n_tests++; if (bus_a.i_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rstw_clr: got %h want %h", bus_a.i_rsp_rdata, 32'h0); end
         end
         if (k == 4) begin
            n_tests++; if (bus_a.mem_addr !== 32'h40) begin n_fail++; $display("FAIL rstw_addr: got %h want %h", bus_a.mem_addr, 32'h40); end
         end
         if (k == 6) begin
            n_tests++; if (bus_a.i_rsp_rdata !== 32'h55AA_55AA) begin n_fail++; $display("FAIL rstw_data: got %h want %h", bus_a.i_rsp_rdata, 32'h55AA_55AA); end
         end
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_i_read();
      test_d_write();
      test_round_robin();
      test_write_no_strobe();
      test_d_prio();
      test_rd_lat3();
      test_rst_in_wait();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous board RAM between two masters of the npc core: instruction fetch (I, read-only) and data access (D, read/write).
- Sits between the core's Imem/Dmem ports and the RAM, inside the FPGA top level, on the stepped core clock domain.
- Serialises accesses with a valid/ready request channel and a valid-only response channel per master. At most one transaction is outstanding.

Parameters:
- ADDR_W, 32, address width for both masters and the RAM.
- DATA_W, 32, data width; must be a multiple of 8.
- RD_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
- D_PRIO, 0, 0 = round-robin on contention; 1 = D always wins contention.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted this cycle when high with i_req_valid
- i_req_addr  in  ADDR_W  fetch address
- i_rsp_valid  out  1  one-cycle pulse, fetch data valid
- i_rsp_rdata  out  DATA_W  fetch data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  data address
- d_req_wen  in  1  1 = write, 0 = read
- d_req_wdata  in  DATA_W  write data
- d_req_wstrb  in  DATA_W/8  byte write enables
- d_rsp_valid  out  1  one-cycle pulse, read data or write acknowledge
- d_rsp_rdata  out  DATA_W  read data; 0 for a write acknowledge
- mem_en  out  1  RAM access strobe, one cycle per transaction
- mem_wen  out  1  RAM write
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wstrb  out  DATA_W/8  RAM byte enables
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready is combinational, high only in IDLE, and only for the granted master.
  - Grant goes to the single valid requester.
  - On contention with D_PRIO=0, grant goes to the master not granted last. The last-grant register resets to D, so I wins the first tie.
  - On contention with D_PRIO=1, D wins.
  - On accept: latch addr, wen, wdata, wstrb and the master id. The ungranted master's request stays pending, and that master must hold its request stable. Next state is ACCESS.
- ACCESS:
  - mem_en=1 for exactly one cycle, driven from the latched fields.
  - mem_wen=1 only for a D write. For reads mem_wstrb is forced to 0.
  - A write goes to RESP. A read goes to WAIT, with a latency counter loaded to RD_LAT-1.
- WAIT:
  - While the counter is non-zero, decrement it.
  - When it reaches 0 (mem_rdata valid this cycle), capture mem_rdata into the response register and go to RESP.
- RESP:
  - Pulse the rsp_valid of the latched master for one cycle. rsp_rdata holds the captured data (0 for writes).
  - The other master's rsp_valid stays 0. Next state is IDLE.
- Outside RESP:
  - rsp_rdata holds its last value.
  - mem_en, mem_wen and mem_wstrb are 0. mem_addr and mem_wdata hold their last latched values.
- Latency, with accept in cycle T:
  - Read: mem_en at T+1, rsp_valid at T+2+RD_LAT.
  - Write: mem_en at T+1, rsp_valid at T+2.
  - Next accept is possible at T+3+RD_LAT for a read, T+3 for a write.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The last-grant register resets to D. The latency counter resets to 0.
  - Reset mid-transaction aborts it: no response is issued, and a write already strobed in ACCESS stays committed in the RAM.
- Boundaries:
  - A request withdrawn before accept is ignored.
  - A request asserted in a non-IDLE state waits; there is no starvation under round-robin.
  - Simultaneous rst and valid: rst wins, no accept.
  - Address is passed through unmodified; no alignment check.
  - mem_wstrb=0 on a write still produces an acknowledge.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE, ACCESS, WAIT, RESP).
  - Master-id constants MID_I=0, MID_D=1.
  - Latency counter width = clog2(RD_LAT+1).
- Sub-module rr_arb2:
  - 2-way grant logic plus the last-grant register.
  - Inputs: req[1:0], prio_d, accept.
  - Output: one-hot gnt[1:0].
- The FSM, request latch and response registers stay in mem_arbiter.

Test Plan:
- Reset, then I read of 0x80000000 with RAM returning 0x00000413 (RD_LAT=1):
  - i_req_ready=1 in cycle 0.
  - mem_en=1 and mem_addr=0x80000000 in cycle 1.
  - i_rsp_valid=1 with rdata 0x00000413 in cycle 3.
  - d_rsp_valid stays 0 throughout.
- D write to addr 0x10, wdata 0xDEADBEEF, wstrb 0x3:
  - mem_en, mem_wen, mem_wstrb=0x3 in cycle 1.
  - d_rsp_valid=1 with rdata 0 in cycle 2.
  - busy falls in cycle 3.
- Both masters valid continuously, D_PRIO=0, RD_LAT=1: grants alternate I, D, I, D, with an accept every 4 cycles and no response lost.
- Same stimulus with D_PRIO=1: D granted every time. I is granted only after D drops valid.
- RD_LAT=3 read: mem_en at T+1, rsp_valid at T+5. Data driven in WAIT cycles other than T+4 must not appear on rsp_rdata.
- rst asserted in the WAIT cycle of a read:
  - No rsp_valid is issued and busy=0 the next cycle.
  - A fresh I request is accepted in the first cycle after rst falls.
